// File: rtl/max_pooling.sv
// max_pooling: P x P max-pool over a D x D map held in an internal scratch RAM.
// Define MAXPOOL_HOST_PORT_EN to expose a host read/write port on that RAM.
module max_pooling #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DIM_WIDTH-1:0]  pool_size,
  input  logic [DIM_WIDTH-1:0]  stride,
  input  logic [ADDR_WIDTH-1:0] input_addr,
  input  logic [ADDR_WIDTH-1:0] output_addr,
  input  logic [DIM_WIDTH-1:0]  dimensions,
`ifdef MAXPOOL_HOST_PORT_EN
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
`endif
  output logic                  valid_out
);
  localparam int CW = 2*DIM_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, WRITE, DONE} state_t;

  state_t r_state, w_next;

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  logic [DIM_WIDTH-1:0]  r_p, r_s, r_d, r_x, r_y;
  logic [CW-1:0]         r_orow, r_ocol;
  logic [ADDR_WIDTH-1:0] r_in, r_out, r_oidx;
  logic [DATA_WIDTH-1:0] r_acc, r_rdata;
  logic                  r_rd_vld, r_vo;

  logic [CW-1:0]         w_i, w_j;
  logic                  w_inb, w_rd;
  logic                  w_xlast, w_ylast, w_clast, w_rlast;
  logic [ADDR_WIDTH-1:0] w_raddr, w_waddr, w_ram_raddr;

  assign w_i     = r_orow + CW'(r_x);
  assign w_j     = r_ocol + CW'(r_y);
  assign w_inb   = (w_i < CW'(r_d)) && (w_j < CW'(r_d));
  assign w_rd    = (r_state == SCAN) && w_inb;
  assign w_raddr = r_in + ADDR_WIDTH'(w_i) * ADDR_WIDTH'(r_d)
                 + ADDR_WIDTH'(w_j);
  assign w_waddr = r_out + r_oidx;
  assign w_xlast = (r_x == r_p - DIM_WIDTH'(1));
  assign w_ylast = (r_y == r_p - DIM_WIDTH'(1));
  // Next origin past the edge means this is the last column/row.
  assign w_clast = (r_ocol + CW'(r_s)) >= CW'(r_d);
  assign w_rlast = (r_orow + CW'(r_s)) >= CW'(r_d);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (valid_in) w_next = SCAN;
      SCAN: begin
        if (r_d == '0)
          w_next = DONE;
        else if (w_xlast && w_ylast)
          w_next = DRAIN;
      end
      DRAIN: w_next = WRITE;
      WRITE: w_next = (w_clast && w_rlast) ? DONE : SCAN;
      DONE:  if (r_vo && !valid_in) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_vo     <= 1'b0;
      r_rd_vld <= 1'b0;
      r_acc    <= '0;
      r_p      <= '0;
      r_s      <= '0;
      r_d      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_orow   <= '0;
      r_ocol   <= '0;
      r_in     <= '0;
      r_out    <= '0;
      r_oidx   <= '0;
    end else begin
      r_state  <= w_next;
      r_vo     <= (r_state == DONE) && (w_next == DONE);
      r_rd_vld <= w_rd;
      if (r_rd_vld && (r_rdata > r_acc))
        r_acc <= r_rdata;
      unique case (r_state)
        IDLE: begin
          if (valid_in) begin
            r_p    <= (pool_size == '0) ? DIM_WIDTH'(1) : pool_size;
            r_s    <= (stride == '0) ? DIM_WIDTH'(1) : stride;
            r_d    <= dimensions;
            r_in   <= input_addr;
            r_out  <= output_addr;
            r_x    <= '0;
            r_y    <= '0;
            r_orow <= '0;
            r_ocol <= '0;
            r_oidx <= '0;
            r_acc  <= '0;
          end
        end
        SCAN: begin
          if (w_ylast) begin
            r_y <= '0;
            r_x <= w_xlast ? '0 : r_x + DIM_WIDTH'(1);
          end else begin
            r_y <= r_y + DIM_WIDTH'(1);
          end
        end
        WRITE: begin
          r_acc  <= '0;
          r_oidx <= r_oidx + ADDR_WIDTH'(1);
          if (w_clast) begin
            r_ocol <= '0;
            r_orow <= r_orow + CW'(r_s);
          end else begin
            r_ocol <= r_ocol + CW'(r_s);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MAXPOOL_HOST_PORT_EN
  logic w_host_ok;
  assign w_host_ok   = (r_state == IDLE) || (r_state == DONE);
  assign w_ram_raddr = (r_state == SCAN) ? w_raddr : host_addr;
  assign host_rdata  = r_rdata;
`else
  assign w_ram_raddr = w_raddr;
`endif

  // Scratch RAM: one write port, one synchronous read port.
  always @(posedge clk) begin
    if (r_state == WRITE)
      mem[w_waddr] <= r_acc;
`ifdef MAXPOOL_HOST_PORT_EN
    else if (host_we && w_host_ok)
      mem[host_addr] <= host_wdata;
`endif
    r_rdata <= mem[w_ram_raddr];
  end

  assign valid_out = r_vo;

endmodule

// File: tb/tb_max_pooling.sv
// tb_max_pooling: random and directed jobs against a loop-based max-pool model.
// Checks latency, handshake, reset abort and every output word.
module tb_max_pooling;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [NW-1:0] pool_size, stride, dimensions;
  logic [AW-1:0] input_addr, output_addr;
  logic          valid_out;
`ifdef MAXPOOL_HOST_PORT_EN
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic [DW-1:0] host_rdata;
`endif

  max_pooling dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .pool_size   (pool_size),
    .stride      (stride),
    .input_addr  (input_addr),
    .output_addr (output_addr),
    .dimensions  (dimensions),
`ifdef MAXPOOL_HOST_PORT_EN
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
`endif
    .valid_out   (valid_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] img [256];

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rd_out(input int oa, input int k);
    return int'(dut.mem[(oa + k) % DEPTH]);
  endfunction

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++)
      img[k] = ($urandom_range(0, 3) == 0) ? $urandom : DW'($urandom_range(0, 999));
  endtask

  task automatic start(input int d, input int p, input int s,
                       input int ia, input int oa);
    for (int k = 0; k < d * d; k++)
      dut.mem[(ia + k) % DEPTH] = img[k];
    @(negedge clk);
    dimensions  = NW'(d);
    pool_size   = NW'(p);
    stride      = NW'(s);
    input_addr  = AW'(ia);
    output_addr = AW'(oa);
    valid_in    = 1'b1;
    @(posedge clk);
    #1;
    dimensions  = NW'($urandom);
    pool_size   = NW'($urandom);
    stride      = NW'($urandom);
    input_addr  = AW'($urandom);
    output_addr = AW'($urandom);
  endtask

  task automatic run_job(input string nm, input int d, input int p,
                         input int s, input int ia, input int oa);
    int pe, se, o, lat, exp_lat;
    logic [DW-1:0] m;
    pe = (p == 0) ? 1 : p;
    se = (s == 0) ? 1 : s;
    o  = (d + se - 1) / se;
    exp_lat = (d == 0) ? 2 : o * o * (pe * pe + 2) + 1;
    start(d, p, s, ia, oa);
    lat = 1;
    while (!valid_out && lat < exp_lat + 20) begin
      @(posedge clk);
      #1;
      if (!valid_out) lat++;
    end
    check({nm, " latency"}, DW'(lat), DW'(exp_lat));
    repeat (3) @(posedge clk);
    #1;
    check({nm, " hold"}, DW'(valid_out), 1);
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    check({nm, " drop"}, DW'(valid_out), 0);
    for (int r = 0; r < o; r++)
      for (int c = 0; c < o; c++) begin
        m = '0;
        for (int x = 0; x < pe; x++)
          for (int y = 0; y < pe; y++)
            if (r * se + x < d && c * se + y < d &&
                img[(r * se + x) * d + c * se + y] > m)
              m = img[(r * se + x) * d + c * se + y];
        check($sformatf("%s out r%0d c%0d", nm, r, c),
              DW'(rd_out(oa, r * o + c)), m);
      end
  endtask

  initial begin
    int seen;
    rst = 1'b0;
    valid_in = 1'b0;
    pool_size = '0;
    stride = '0;
    dimensions = '0;
    input_addr = '0;
    output_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset vo", DW'(valid_out), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 16; k++) img[k] = DW'(k);
    run_job("p2s2", 4, 2, 2, 0, 512);
    check("p2s2 o0", DW'(rd_out(512, 0)), 5);
    check("p2s2 o1", DW'(rd_out(512, 1)), 7);
    check("p2s2 o2", DW'(rd_out(512, 2)), 13);
    check("p2s2 o3", DW'(rd_out(512, 3)), 15);

    run_job("p3s1", 4, 3, 1, 0, 600);
    check("p3s1 o0", DW'(rd_out(600, 0)), 10);
    check("p3s1 o3", DW'(rd_out(600, 3)), 11);
    check("p3s1 o15", DW'(rd_out(600, 15)), 15);

    fill_random(36);
    run_job("copy", 6, 1, 1, 100, 700);

    img[0] = 5; img[1] = 32'hFFFF_FFFF; img[2] = 3; img[3] = 7;
    run_job("unsigned", 2, 2, 2, 200, 800);
    check("unsigned o0", DW'(rd_out(800, 0)), 32'hFFFF_FFFF);

    dut.mem[900] = 32'hDEAD_BEEF;
    run_job("d0", 0, 2, 2, 0, 900);
    check("d0 untouched", DW'(rd_out(900, 0)), 32'hDEAD_BEEF);

    fill_random(25);
    run_job("p0s0", 5, 0, 0, 300, 1000);
    fill_random(25);
    run_job("wrap", 5, 2, 3, 4080, 1100);

    for (int t = 0; t < 4; t++) begin
      int d;
      d = $urandom_range(1, 8);
      fill_random(d * d);
      run_job($sformatf("rnd%0d", t), d, $urandom_range(0, 4),
              $urandom_range(0, 3), $urandom_range(0, 1000),
              $urandom_range(2048, 3000));
    end

    start(0, 1, 1, 0, 1200);
    seen = 0;
    for (int k = 0; k < 5 && seen == 0; k++) begin
      @(posedge clk);
      #1;
      if (valid_out) seen = 1;
    end
    check("done reached", DW'(seen), 1);
    #2 rst = 1'b0;
    #1 check("rst in done", DW'(valid_out), 0);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    fill_random(36);
    start(6, 3, 1, 0, 1300);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("rst mid scan", DW'(valid_out), 0);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (valid_out) seen = 1;
    end
    check("abort idle", DW'(seen), 0);
    run_job("restart", 6, 3, 1, 0, 1300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/max_pooling.md
Name: max_pooling

Overview:
- 2-D max-pooling engine for square feature maps held in a block-internal word-addressed scratch RAM.
- On start it scans a dimensions x dimensions input map at input_addr with a pool_size x pool_size window stepping by stride.
- It writes each window maximum into the output map at output_addr, then raises valid_out.
- Sits beside the core as a memory-mapped accelerator; the host preloads and reads back the scratch RAM.

Parameters:
ADDR_WIDTH 12 scratch RAM address width; RAM depth 2^ADDR_WIDTH words
DATA_WIDTH 32 element width; elements compared as unsigned
DIM_WIDTH 4 width of pool_size, stride, dimensions

Ports:
clk input 1 clock, rising edge
rst input 1 asynchronous active-low reset
valid_in input 1 start request, level-sensitive
pool_size input DIM_WIDTH window edge P
stride input DIM_WIDTH window step S
input_addr input ADDR_WIDTH base word address of the input map
output_addr input ADDR_WIDTH base word address of the output map
dimensions input DIM_WIDTH input map edge D
valid_out output 1 job complete

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst).
- rst low forces the FSM to IDLE and valid_out to 0, and aborts any job. RAM contents are not cleared.
- FSM states: IDLE, SCAN, DRAIN, WRITE, DONE.
- IDLE: when valid_in=1 is sampled, latch P, S, D and both base addresses, clear counters, and go to SCAN. Port changes after latching are ignored.
- Degenerate parameters: P=0 is treated as 1 and S=0 is treated as 1. If D=0, go directly to DONE with no writes.
- Output edge O = ceil(D/S). Output rows r and columns c run 0..O-1 in raster order. The window origin is (r*S, c*S).
- SCAN: visit one window position (x,y) per cycle, x and y in 0..P-1, row-major, for P*P cycles.
  - If origin row + x < D and origin column + y < D, issue a read of input_addr + i*D + j. The RAM has 1-cycle synchronous read.
  - Out-of-bounds positions still take a cycle but do not contribute.
- Accumulator: reset to 0 at each window start. Each returned word replaces it when the word is strictly greater, using an unsigned DATA_WIDTH compare.
- DRAIN: 1 cycle to absorb the final read.
- WRITE: 1 cycle; store the accumulator at output_addr + r*O + c. Then go to SCAN for the next window, or to DONE after the last window.
- Cost is P*P+2 cycles per window. valid_out rises O*O*(P*P+2)+1 cycles after the edge that sampled valid_in.
- DONE: valid_out=1 (registered). Stay in DONE while valid_in=1. When valid_in=0, go to IDLE and drop valid_out on the next cycle.
- Address arithmetic is modulo 2^ADDR_WIDTH (wraps). Overlapping input and output regions are not protected; the result is then undefined.
- The scratch RAM is a reg array, accessible hierarchically as mem for bench preload and readback.

Optional Feature:
- Macro MAXPOOL_HOST_PORT_EN.
- When defined, add host ports: host_we (1), host_addr (ADDR_WIDTH), host_wdata (DATA_WIDTH), host_rdata (DATA_WIDTH, 1-cycle read latency).
- Host access is honoured only in IDLE and DONE. host_we is ignored in SCAN, DRAIN and WRITE.
- When undefined, these ports are absent and the RAM is reachable only hierarchically.

Test Plan:
- D=4, P=2, S=2, inputs 0..15 at base 0, output_addr=512 -> mem[512..515] = 5, 7, 13, 15. valid_out rises 4*(4+2)+1 = 25 cycles after start.
- D=4, P=3, S=1, inputs 0..15 -> O=4 with edge-clipped windows. out[0]=10, out[3]=11, out[15]=15.
- D=6, P=1, S=1, random data -> output is an exact copy of the input (36 words).
- Unsigned compare: D=2, P=2, S=2, data {5, 0xFFFFFFFF, 3, 7} -> out[0]=0xFFFFFFFF.
- D=0 start -> valid_out=1 two cycles after the sampling edge, no RAM writes.
- Reset and handshake: assert rst low mid-SCAN -> valid_out=0 and FSM returns to IDLE. Restarting then completes correctly. After DONE, dropping valid_in clears valid_out the next cycle.
